// File: rtl/bit_unstuffer_gen.sv
// Bit unstuffer: strips zeros stuffed after RUN_LEN ones, checks the PID and buffers
// unstuffed bits in a small FIFO presented on a valid/ready output with packet framing.
module bit_unstuffer_gen #(
    parameter int RUN_LEN   = 6,
    parameter int PID_BITS  = 8,
    parameter int DEPTH     = 32,
    parameter bit CHECK_PID = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic abort,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_sop,
    input  logic in_eop,
    output logic out_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_sop,
    output logic out_eop,
    output logic pid_error,
    output logic stuff_error,
    output logic overflow,
    output logic busy
);
    // state | meaning
    // IDLE  | waiting for in_sop
    // PID   | collecting PID bits (pushed to FIFO, output held)
    // DATA  | unstuffing payload, newest bit held back until eop
    // DRAIN | eop seen, emptying FIFO
    // FLUSH | one-cycle cleanup after an error
    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_DRAIN, S_FLUSH} state_t;

    localparam int CW    = $clog2(RUN_LEN + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = AW + 1;
    localparam int PCW   = $clog2(PID_BITS + 1);
    localparam int HALF  = PID_BITS / 2;
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);
    localparam logic [NW-1:0] FULL    = NW'(DEPTH);
    localparam logic [NW-1:0] ONE     = NW'(1);
    localparam logic [NW-1:0] TWO     = NW'(2);

    state_t              state, state_n;
    logic [CW-1:0]       ones_cnt, ones_n, ones_b;
    logic [PCW-1:0]      pid_cnt, pid_cnt_n, pcnt_b;
    logic [PID_BITS-1:0] pid_reg, pid_n;
    logic [AW-1:0]       wr_ptr, rd_ptr, wr_b, rd_b, wr_n, rd_n;
    logic [NW-1:0]       count, cnt_b, count_n;
    logic                mem [DEPTH];
    logic                sop_pend, sop_pend_n;
    logic                clr, start, accept, push, pop, pop_eff, in_pid;
    logic                pid_err_n, stuff_err_n, ovf_n;

    always_comb begin
        out_valid = 1'b0;
        if (!abort) begin
            if (state == S_DATA)       out_valid = (count >= TWO);
            else if (state == S_DRAIN) out_valid = (count != '0);
        end
    end

    assign pop     = out_valid & out_ready;
    assign out_bit = out_valid & mem[rd_ptr];
    assign out_sop = out_valid & sop_pend;
    assign out_eop = out_valid & (state == S_DRAIN) & (count == ONE);
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_n     = state;
        clr         = 1'b0;
        start       = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        pid_err_n   = 1'b0;
        stuff_err_n = 1'b0;
        ovf_n       = 1'b0;
        ones_b      = ones_cnt;
        pcnt_b      = pid_cnt;
        pid_n       = pid_reg;
        in_pid      = (state == S_PID);

        if (abort) begin
            state_n = S_IDLE;
            clr     = 1'b1;
            ones_b  = '0;
            pcnt_b  = '0;
        end else if (in_valid && in_sop && state != S_FLUSH) begin
            // new packet start, also drops any packet in progress
            state_n = S_PID;
            clr     = 1'b1;
            start   = 1'b1;
            accept  = 1'b1;
            in_pid  = 1'b1;
            ones_b  = '0;
            pcnt_b  = '0;
            pid_n   = '0;
        end else begin
            case (state)
                S_PID: begin
                    if (in_eop) begin
                        pid_err_n = 1'b1;
                        state_n   = S_FLUSH;
                    end else begin
                        accept = in_valid;
                    end
                end
                S_DATA: begin
                    if (in_eop) state_n = S_DRAIN;
                    else        accept  = in_valid;
                end
                S_DRAIN: begin
                    if (count == '0 || (pop && count == ONE)) state_n = S_IDLE;
                end
                S_FLUSH: begin
                    clr     = 1'b1;
                    ones_b  = '0;
                    pcnt_b  = '0;
                    state_n = S_IDLE;
                end
                default: ;
            endcase
        end

        ones_n    = ones_b;
        pid_cnt_n = pcnt_b;
        cnt_b     = clr ? '0 : count;
        wr_b      = clr ? '0 : wr_ptr;
        rd_b      = clr ? '0 : rd_ptr;
        pop_eff   = pop & ~clr;

        if (accept) begin
            if (ones_b == RUN_MAX) begin
                ones_n = '0;
                if (in_bit) begin
                    stuff_err_n = 1'b1;
                    state_n     = S_FLUSH;
                end
            end else if (cnt_b == FULL && !pop_eff) begin
                ovf_n   = 1'b1;
                state_n = S_FLUSH;
            end else begin
                push   = 1'b1;
                ones_n = in_bit ? ones_b + CW'(1) : '0;
                if (in_pid) begin
                    for (int i = 0; i < PID_BITS; i++)
                        if (pcnt_b == PCW'(i)) pid_n[i] = in_bit;
                    pid_cnt_n = pcnt_b + PCW'(1);
                    if (pcnt_b == PCW'(PID_BITS - 1)) begin
                        if (CHECK_PID && (pid_n[PID_BITS-1 -: HALF] != ~pid_n[HALF-1:0])) begin
                            pid_err_n = 1'b1;
                            state_n   = S_FLUSH;
                        end else begin
                            state_n = S_DATA;
                        end
                    end
                end
            end
        end

        wr_n    = wr_b + AW'(push);
        rd_n    = rd_b + AW'(pop_eff);
        count_n = cnt_b + NW'(push) - NW'(pop_eff);

        if (start)        sop_pend_n = 1'b1;
        else if (clr)     sop_pend_n = 1'b0;
        else if (pop)     sop_pend_n = 1'b0;
        else              sop_pend_n = sop_pend;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_b] <= in_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ones_cnt    <= '0;
            pid_cnt     <= '0;
            pid_reg     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sop_pend    <= 1'b0;
            pid_error   <= 1'b0;
            stuff_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            ones_cnt    <= ones_n;
            pid_cnt     <= pid_cnt_n;
            pid_reg     <= pid_n;
            wr_ptr      <= wr_n;
            rd_ptr      <= rd_n;
            count       <= count_n;
            sop_pend    <= sop_pend_n;
            pid_error   <= pid_err_n;
            stuff_error <= stuff_err_n;
            overflow    <= ovf_n;
        end
    end
endmodule

// File: tb/tb_bit_unstuffer_gen.sv
// Scoreboard bench for bit_unstuffer_gen: stimulus queues expected output bits,
// a negedge monitor pops and compares every output transfer.
module tb_bit_unstuffer_gen;
    logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
    logic in_bit = 1'b0, in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_ready = 1'b0;
    logic out_bit, out_valid, out_sop, out_eop, pid_error, stuff_error, overflow, busy;

    always #5 clk = ~clk;

    bit_unstuffer_gen #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_bit(in_bit), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop),
        .pid_error(pid_error), .stuff_error(stuff_error), .overflow(overflow), .busy(busy)
    );

    typedef struct packed {logic b; logic sop; logic eop;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0, n_pass = 0;
    int n_xfer = 0, n_valid = 0, n_eop = 0, n_pid = 0, n_stuff = 0, n_ovf = 0;
    int s_xfer, s_valid, s_eop, s_pid, s_stuff, s_ovf;
    bit mute = 1'b0, toggle = 1'b0, first = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pid_error)   n_pid++;
            if (stuff_error) n_stuff++;
            if (overflow)    n_ovf++;
            if (out_valid)   n_valid++;
            if (out_valid && out_ready) begin
                n_xfer++;
                if (out_eop) n_eop++;
                if (!mute) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL xfer_unexpected: got bit %0b sop %0b eop %0b with nothing expected",
                                 out_bit, out_sop, out_eop);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("xfer {bit,sop,eop}", {29'd0, out_bit, out_sop, out_eop},
                              {29'd0, mon_e.b, mon_e.sop, mon_e.eop});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) out_ready = ~out_ready;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b, input logic sop, input bit expect_it);
        exp_t t;
        in_bit   = b;
        in_valid = 1'b1;
        in_sop   = sop;
        if (expect_it && !mute) begin
            t.b = b; t.sop = first; t.eop = 1'b0;
            exp_q.push_back(t);
            first = 1'b0;
        end
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_pid(input logic [7:0] p);
        first = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(p[i], (i == 0), 1'b1);
    endtask

    task automatic send_data(input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) drive_bit(d[i], 1'b0, 1'b1);
    endtask

    task automatic send_eop();
        exp_t t;
        if (!mute && exp_q.size() > 0) begin
            t = exp_q.pop_back();
            t.eop = 1'b1;
            exp_q.push_back(t);
        end
        in_eop = 1'b1;
        tick();
        in_eop = 1'b0;
    endtask

    task automatic snap();
        s_xfer = n_xfer; s_valid = n_valid; s_eop = n_eop;
        s_pid = n_pid; s_stuff = n_stuff; s_ovf = n_ovf;
    endtask

    task automatic check_errs(input string name, input int dp, input int ds, input int dov);
        check({name, " pid_error pulses"},   n_pid - s_pid, dp);
        check({name, " stuff_error pulses"}, n_stuff - s_stuff, ds);
        check({name, " overflow pulses"},    n_ovf - s_ovf, dov);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        check("reset outputs", {24'd0, out_bit, out_valid, out_sop, out_eop,
                                pid_error, stuff_error, overflow, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // bit without sop after reset is ignored
        drive_bit(1'b1, 1'b0, 1'b0);
        check("no sop stays idle", busy, 1'b0);

        // clean packet: PID E1 + 16 data bits
        snap();
        send_pid(8'hE1);
        send_data(16'b0101_0011_1001_0110, 16);
        send_eop();
        idle(14);
        check("t1 scoreboard empty", exp_q.size(), 0);
        check("t1 transfer count", n_xfer - s_xfer, 24);
        check("t1 eop count", n_eop - s_eop, 1);
        check_errs("t1", 0, 0, 0);
        check("t1 busy after", busy, 1'b0);

        // stuffed zero after six ones is removed
        snap();
        send_pid(8'h5A);
        for (int i = 0; i < 6; i++) drive_bit(1'b1, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b1);
        send_eop();
        idle(14);
        check("t2 scoreboard empty", exp_q.size(), 0);
        check("t2 transfer count", n_xfer - s_xfer, 15);
        check("t2 eop count", n_eop - s_eop, 1);
        check_errs("t2", 0, 0, 0);

        // seven ones: stuff error
        mute = 1'b1;
        snap();
        send_pid(8'h5A);
        for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0, 1'b0);
        check("t3 stuff pulse", stuff_error, 1'b1);
        tick();
        check("t3 busy two cycles later", busy, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        send_eop();
        idle(3);
        check_errs("t3", 0, 1, 0);
        check("t3 no eop", n_eop - s_eop, 0);
        mute = 1'b0;

        // bad PID E0
        mute = 1'b1;
        snap();
        send_pid(8'hE0);
        idle(4);
        check_errs("t4", 1, 0, 0);
        check("t4 out_valid never", n_valid - s_valid, 0);
        // eop during PID
        snap();
        first = 1'b1;
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        send_eop();
        idle(3);
        check_errs("t4 eop in pid", 1, 0, 0);
        check("t4 busy after", busy, 1'b0);
        mute = 1'b0;

        // overflow with DEPTH 8, out_ready low
        out_ready = 1'b0;
        mute = 1'b1;
        snap();
        send_pid(8'h5A);
        drive_bit(1'b1, 1'b0, 1'b0);
        check("t5 overflow on 9th push", overflow, 1'b1);
        for (int i = 1; i < 8; i++) drive_bit(i[0], 1'b0, 1'b0);
        send_eop();
        idle(3);
        check_errs("t5", 0, 0, 1);
        check("t5 no eop", n_eop - s_eop, 0);
        mute = 1'b0;

        // toggling out_ready on a clean packet
        snap();
        toggle = 1'b1;
        send_pid(8'h5A);
        idle(8);
        begin
            logic [5:0] d;
            d = 6'b00_1101;
            for (int i = 0; i < 6; i++) begin
                drive_bit(d[i], 1'b0, 1'b1);
                idle(2);
            end
        end
        send_eop();
        idle(30);
        toggle = 1'b0;
        out_ready = 1'b1;
        check("t5b scoreboard empty", exp_q.size(), 0);
        check("t5b transfer count", n_xfer - s_xfer, 14);
        check("t5b eop count", n_eop - s_eop, 1);
        check_errs("t5b", 0, 0, 0);

        // abort in DATA
        out_ready = 1'b0;
        mute = 1'b1;
        snap();
        send_pid(8'h5A);
        abort = 1'b1;
        #1;
        check("t6 out_valid low during abort", out_valid, 1'b0);
        tick();
        abort = 1'b0;
        check("t6 busy after abort", busy, 1'b0);
        idle(2);
        check_errs("t6", 0, 0, 0);
        mute = 1'b0;
        out_ready = 1'b1;
        snap();
        send_pid(8'hE1);
        send_data(16'h009A, 8);
        send_eop();
        idle(14);
        check("t6 scoreboard empty", exp_q.size(), 0);
        check("t6 transfer count", n_xfer - s_xfer, 16);
        check("t6 eop count", n_eop - s_eop, 1);
        check_errs("t6 next packet", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
